// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : capture_sequencer
// Brief    : Circular pre-trigger capture into a 2^ADDR_W x DATA_W SRAM,
//            fixed post-trigger window, then time-ordered valid/ready readout.
// Revision : 1.0
// ============================================================================
module capture_sequencer #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 21,
    parameter int PRETRIG = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              trig,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_din,
    output logic [ADDR_W-1:0] sram_addr_r,
    input  logic [DATA_W-1:0] sram_dout,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] c_PRE       = ADDR_W'(PRETRIG);
    localparam logic [ADDR_W-1:0] c_PRE_LAST  = ADDR_W'(PRETRIG - 1);
    // Index of the final post-trigger sample, counting only those after the trigger.
    localparam logic [ADDR_W-1:0] c_POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
    localparam bit                c_NO_PRE     = (PRETRIG == 0);
    localparam bit                c_POST_EMPTY = (PRETRIG == DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_FLUSH = 3'd4,
        S_READ  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_rd_cnt;

    logic              w_accept;
    logic              w_take;
    logic              w_xfer;
    logic              w_rd_last;

    assign w_accept  = adc_valid &&
                       ((r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST));
    assign w_take    = w_accept && !abort;
    assign w_xfer    = (r_state == S_READ) && rd_ready;
    assign w_rd_last = (r_rd_cnt == {ADDR_W{1'b1}});

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    if (c_NO_PRE) w_next = S_ARMED;
                    else          w_next = S_FILL;
                end
            end
            S_FILL: begin
                if (w_accept && (r_fill_cnt == c_PRE_LAST)) w_next = S_ARMED;
            end
            S_ARMED: begin
                if (w_accept && trig) begin
                    if (c_POST_EMPTY) w_next = S_FLUSH;
                    else              w_next = S_POST;
                end
            end
            S_POST: begin
                if (w_accept && (r_post_cnt == c_POST_LAST)) w_next = S_FLUSH;
            end
            S_FLUSH: w_next = S_READ;
            S_READ: begin
                if (w_xfer && w_rd_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_post_cnt <= '0;
            r_rd_ptr   <= '0;
            r_rd_cnt   <= '0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            trig_addr  <= '0;
        end else begin
            r_state <= w_next;
            sram_we <= w_take;

            if (w_take) begin
                sram_addr <= r_wr_ptr;
                sram_din  <= adc_data;
                r_wr_ptr  <= r_wr_ptr + 1'b1;
            end

            if ((r_state == S_IDLE) && arm && !abort) begin
                r_wr_ptr   <= '0;
                r_fill_cnt <= '0;
                r_post_cnt <= '0;
            end

            if (w_take && (r_state == S_FILL))
                r_fill_cnt <= r_fill_cnt + 1'b1;

            if (w_take && (r_state == S_ARMED) && trig)
                trig_addr <= r_wr_ptr;

            if (w_take && (r_state == S_POST))
                r_post_cnt <= r_post_cnt + 1'b1;

            // Oldest retained sample sits PRETRIG slots behind the trigger.
            if ((r_state == S_FLUSH) && !abort) begin
                r_rd_ptr <= trig_addr - c_PRE;
                r_rd_cnt <= '0;
            end

            if (w_xfer && !abort) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    assign sram_addr_r = r_rd_ptr;
    assign rd_data     = sram_dout;
    assign rd_valid    = (r_state == S_READ);
    assign busy        = (r_state != S_IDLE);
    assign done        = w_xfer && w_rd_last && !abort;

endmodule
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_sequencer
// Brief    : Self-checking bench: vector table for control corners, then
//            full capture/readout sequences against two PRETRIG settings.
// Revision : 1.0
// ============================================================================
module tb_capture_sequencer;

    localparam int AW = 11;
    localparam int DW = 21;

    logic          clk;
    logic          rst_n;
    logic          arm;
    logic          abort;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic          trig;
    logic          rd_ready;

    logic [AW-1:0] sram_addr0, sram_addr_r0, trig_addr0;
    logic [AW-1:0] sram_addr1, sram_addr_r1, trig_addr1;
    logic [DW-1:0] sram_din0, sram_dout0, rd_data0;
    logic [DW-1:0] sram_din1, sram_dout1, rd_data1;
    logic          sram_we0, rd_valid0, busy0, done0;
    logic          sram_we1, rd_valid1, busy1, done1;

    logic [DW-1:0] mem0 [2048];
    logic [DW-1:0] mem1 [2048];

    int n_checks = 0;
    int n_fail   = 0;

    logic          sel;
    logic          m_rd_valid, m_busy, m_done;
    logic [DW-1:0] m_rd_data;
    logic [AW-1:0] m_trig, m_addr_r;

    capture_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PRETRIG(256)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .adc_data(adc_data), .adc_valid(adc_valid), .trig(trig),
        .sram_addr(sram_addr0), .sram_we(sram_we0), .sram_din(sram_din0),
        .sram_addr_r(sram_addr_r0), .sram_dout(sram_dout0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready),
        .trig_addr(trig_addr0), .busy(busy0), .done(done0)
    );

    capture_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PRETRIG(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .adc_data(adc_data), .adc_valid(adc_valid), .trig(trig),
        .sram_addr(sram_addr1), .sram_we(sram_we1), .sram_din(sram_din1),
        .sram_addr_r(sram_addr_r1), .sram_dout(sram_dout1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready),
        .trig_addr(trig_addr1), .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        if (sram_we0) mem0[sram_addr0] <= sram_din0;
        if (sram_we1) mem1[sram_addr1] <= sram_din1;
    end
    assign sram_dout0 = mem0[sram_addr_r0];
    assign sram_dout1 = mem1[sram_addr_r1];

    assign m_rd_valid = sel ? rd_valid1   : rd_valid0;
    assign m_busy     = sel ? busy1       : busy0;
    assign m_done     = sel ? done1       : done0;
    assign m_rd_data  = sel ? rd_data1    : rd_data0;
    assign m_trig     = sel ? trig_addr1  : trig_addr0;
    assign m_addr_r   = sel ? sram_addr_r1 : sram_addr_r0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          arm;
        logic          abort;
        logic          valid;
        logic          trig;
        logic [DW-1:0] data;
        logic          e_busy;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; adc_valid = 1'b0; trig = 1'b0;
        rd_ready = 1'b0; adc_data = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Feeds sample indices 0..last_n; gapped mode inserts invalid cycles carrying random trig.
    task automatic feed(input int trig_n, input int last_n, input int off,
                        input bit gapped, input bit early);
        int  n = 0;
        int  guard = 0;
        bit  v;
        while (n <= last_n && guard < 20000) begin
            v = gapped ? ($urandom_range(0, 3) != 0) : 1'b1;
            adc_valid = v;
            adc_data  = v ? DW'(n + off) : {DW{1'b1}};
            if (v) trig = (n == trig_n) || (early && n < 256);
            else   trig = gapped ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (v) n++;
            guard++;
        end
        adc_valid = 1'b0;
        trig      = 1'b0;
        if (n <= last_n) chk("feed_timeout", n, last_n + 1);
    endtask

    task automatic post_capture(input logic s, input int exp_trig, input int exp_first);
        sel = s;
        rd_ready = 1'b0;
        #1;
        chk("flush_busy", m_busy, 1);
        chk("flush_rd_valid", m_rd_valid, 0);
        chk("trig_addr", m_trig, exp_trig);
        tick();
        chk("read_rd_valid", m_rd_valid, 1);
        chk("first_rd_addr", m_addr_r, exp_first);
    endtask

    task automatic read_out(input int first, input bit rnd);
        int            k = 0;
        int            cyc = 0;
        bit            stalled = 0;
        logic [DW-1:0] held = '0;
        while (k < 2048 && cyc < 20000) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) begin
                chk("rd_data_stable", m_rd_data, held);
                chk("rd_valid_stalled", m_rd_valid, 1);
                stalled = 0;
            end
            if (m_rd_valid) begin
                if (rd_ready) begin
                    chk("rd_data", m_rd_data, (first + k) & 32'h1FFFFF);
                    chk("done", m_done, (k == 2047));
                    k++;
                end else begin
                    stalled = 1;
                    held    = m_rd_data;
                end
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        if (k < 2048) chk("readout_timeout", k, 2048);
        #1;
        chk("busy_after_done", m_busy, 0);
    endtask

    initial begin
        sel = 1'b0;
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; adc_valid = 1'b0; trig = 1'b0;
        rd_ready = 1'b0; adc_data = '0;

        //           rst   arm   abort valid trig  data     busy  we    addr    din
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 21'h00, 1'b0, 1'b0, 11'd0, 21'h00};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 21'h05, 1'b0, 1'b0, 11'd0, 21'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 21'h00, 1'b1, 1'b0, 11'd0, 21'h00};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 21'h11, 1'b1, 1'b1, 11'd0, 21'h11};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 21'h22, 1'b1, 1'b0, 11'd0, 21'h11};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 21'h33, 1'b1, 1'b1, 11'd1, 21'h33};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 21'h44, 1'b1, 1'b1, 11'd2, 21'h44};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 21'h55, 1'b0, 1'b0, 11'd2, 21'h44};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 21'h66, 1'b0, 1'b0, 11'd2, 21'h44};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 21'h00, 1'b0, 1'b0, 11'd2, 21'h44};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 21'h00, 1'b1, 1'b0, 11'd2, 21'h44};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 21'h77, 1'b1, 1'b1, 11'd0, 21'h77};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 21'h88, 1'b0, 1'b0, 11'd0, 21'h00};

        for (int i = 0; i < 13; i++) begin
            rst_n     = vecs[i].rst_n;
            arm       = vecs[i].arm;
            abort     = vecs[i].abort;
            adc_valid = vecs[i].valid;
            trig      = vecs[i].trig;
            adc_data  = vecs[i].data;
            tick();
            chk($sformatf("vec%0d_busy", i), busy0, vecs[i].e_busy);
            chk($sformatf("vec%0d_we", i), sram_we0, vecs[i].e_we);
            chk($sformatf("vec%0d_addr", i), sram_addr0, vecs[i].e_addr);
            chk($sformatf("vec%0d_din", i), sram_din0, vecs[i].e_din);
            chk($sformatf("vec%0d_trig_addr", i), trig_addr0, 0);
        end

        // Ramp: trigger on sample 1000.
        do_reset(); do_arm();
        feed(1000, 2791, 0, 1'b0, 1'b0);
        post_capture(1'b0, 1000, 744);
        read_out(744, 1'b0);

        // Wrap: trigger on sample 5000 -> address 904.
        do_reset(); do_arm();
        feed(5000, 6791, 0, 1'b0, 1'b0);
        post_capture(1'b0, 904, 648);
        read_out(4744, 1'b0);

        // Backpressure with gapped samples and stray trig on invalid cycles.
        do_reset(); do_arm();
        feed(600, 2391, 0, 1'b1, 1'b0);
        post_capture(1'b0, 600, 344);
        read_out(344, 1'b1);

        // PRETRIG = 0 instance: trigger on the very first sample.
        do_reset(); do_arm();
        chk("pre0_busy_after_arm", busy1, 1);
        feed(0, 2047, 0, 1'b0, 1'b0);
        post_capture(1'b1, 0, 0);
        read_out(0, 1'b0);
        sel = 1'b0;

        // Early trig on every FILL sample (including the last) is ignored.
        do_reset(); do_arm();
        feed(300, 2091, 0, 1'b0, 1'b1);
        post_capture(1'b0, 300, 44);
        read_out(44, 1'b0);

        // Abort mid-POST.
        do_reset(); do_arm();
        feed(260, 300, 0, 1'b0, 1'b0);
        chk("pre_abort_busy", busy0, 1);
        abort = 1'b1; adc_valid = 1'b1; adc_data = 21'h1234;
        tick();
        abort = 1'b0; adc_valid = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_we", sram_we0, 0);
        chk("abort_trig_held", trig_addr0, 260);

        // Re-arm, trig on first ARMED sample, then reset during READ.
        do_arm();
        feed(256, 2047, 0, 1'b0, 1'b0);
        post_capture(1'b0, 256, 0);
        for (int k = 0; k < 5; k++) begin
            rd_ready = 1'b1;
            #1;
            chk("pre_reset_rd_data", rd_data0, k);
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("rst_busy", busy0, 0);
        chk("rst_we", sram_we0, 0);
        chk("rst_addr", sram_addr0, 0);
        chk("rst_din", sram_din0, 0);
        chk("rst_addr_r", sram_addr_r0, 0);
        chk("rst_rd_valid", rd_valid0, 0);
        chk("rst_trig_addr", trig_addr0, 0);
        chk("rst_done", done0, 0);
        rst_n = 1'b1; rd_ready = 1'b0;

        do_arm();
        feed(400, 2191, 32'h10000, 1'b0, 1'b0);
        post_capture(1'b0, 400, 144);
        read_out(32'h10000 + 144, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
